adler32_checker: RTL and testbench
==================================

ADLER32_CHECKER -- requirements
Module: adler32_checker

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports named clock and rst_n.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 data_valid  input  1  byte on data is accepted this cycle.
REQ-005 last_data  input  1  accepted byte is the final payload byte; sampled only with data_valid=1 in PAYLOAD.
REQ-006 data  input  8  stream byte: payload bytes, then 4 trailer bytes.
REQ-007 result_valid  output  1  one-cycle pulse: frame check complete.
REQ-008 checksum_ok  output  1  computed checksum equals received trailer; meaningful while result_valid=1.
REQ-009 computed_checksum  output  32  {B,A} of the payload; held until next result.
REQ-010 received_checksum  output  32  assembled trailer; held until next result.
REQ-011 busy  output  1  high while in TRAILER state.

Function
REQ-012 SHALL be a two-state FSM: PAYLOAD (accumulate) and TRAILER (collect 4 checksum bytes).
REQ-013 PAYLOAD, data_valid=1: A <= (A + data) mod 65521; B <= (B + A_new) mod 65521, where A_new is this cycle's updated A.
REQ-014 Modular add: 17-bit intermediate sum; subtract 65521 once when sum >= 65521; result 16 bits; no truncation before compare.
REQ-015 PAYLOAD, data_valid=1 and last_data=1: byte accumulated, then FSM -> TRAILER, trailer count = 0.
REQ-016 TRAILER, data_valid=1: byte captured in order B[15:8], B[7:0], A[15:8], A[7:0] (big-endian, zlib order); count increments.
REQ-017 last_data in TRAILER SHALL be ignored.
REQ-018 data_valid=0 in either state: no state, count, or accumulator change (stall).
REQ-019 On 4th trailer byte edge: FSM -> PAYLOAD; A <= 1, B <= 0; computed_checksum, received_checksum, checksum_ok registered.
REQ-020 result_valid SHALL be 1 for exactly the cycle following acceptance of the 4th trailer byte (latency 1).
REQ-021 A payload byte accepted in the result_valid cycle SHALL begin the next frame (back-to-back frames, no bubble).
REQ-022 Zero-length payload is not supported; every frame has >= 1 payload byte.
REQ-023 checksum_ok = (computed == received) over all 32 bits.

Reset
REQ-024 On rst_n=0, asynchronously: FSM=PAYLOAD, A=1, B=0, trailer count=0, trailer shift register=0.
REQ-025 Reset values of outputs: result_valid=0, checksum_ok=0, computed_checksum=0x00000001, received_checksum=0, busy=0.
REQ-026 Reset mid-frame (either state) SHALL discard the frame; no result_valid for it.

Structure
REQ-027 Shared package adler32_pkg SHALL hold MOD_ADLER=65521, ADLER_A_INIT=1, ADLER_B_INIT=0, TRAILER_BYTES=4, and the FSM state enum.
REQ-028 One sub-module, adler32_mod_add (16-bit + 16-bit mod 65521, combinational), SHALL be instantiated twice (A and B paths).

Verification
REQ-029 "Wikipedia" (57 69 6B 69 70 65 64 69 61, last on 0x61), trailer 11 E6 03 98 -> result_valid pulse, computed=0x11E60398, checksum_ok=1.
REQ-030 Single byte 0xFF with last_data, trailer 01 00 01 00 -> computed=0x01000100, ok=1; same with trailer 01 00 01 01 -> ok=0, received=0x01000101.
REQ-031 257 bytes of 0xFF -> computed A field=0x000F (wrap), B matches reference model; correct trailer -> ok=1.
REQ-032 Random data_valid gaps in payload and trailer, last_data=1 asserted during trailer and with data_valid=0 -> results identical to gap-free run.
REQ-033 Two frames back-to-back, frame 2 first byte in result_valid cycle -> two pulses, frame 2 computed from A=1,B=0.
REQ-034 rst_n pulsed after 2nd trailer byte -> no result_valid; following frame 0x00 + trailer 00 01 00 01 -> computed=0x00010001, ok=1.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared constants and FSM state type for the Adler-32 frame checker.
// Everything here is consumed by adler32_checker and adler32_mod_add.
package adler32_pkg;

  localparam logic [16:0] MOD_ADLER     = 17'd65521;
  localparam logic [15:0] ADLER_A_INIT  = 16'd1;
  localparam logic [15:0] ADLER_B_INIT  = 16'd0;
  localparam int unsigned TRAILER_BYTES = 4;

  typedef enum logic {
    ST_PAYLOAD = 1'b0,
    ST_TRAILER = 1'b1
  } state_t;

endpackage

// File: rtl/adler32_mod_add.sv
// Combinational (x + y) mod 65521 for operands already reduced below 65521.
// Latency 0; no flow control.
module adler32_mod_add
  import adler32_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum
);

  logic [16:0] raw;
  logic [16:0] reduced;

  // Both operands are < 65521, so one conditional subtract fully reduces.
  assign raw     = {1'b0, x} + {1'b0, y};
  assign reduced = raw - MOD_ADLER;
  assign sum     = (raw >= MOD_ADLER) ? reduced[15:0] : raw[15:0];

endmodule

// File: rtl/adler32_checker.sv
// Streams payload bytes through Adler-32, then compares against a 4-byte big-endian trailer.
// Result registered one cycle after the last trailer byte; input is always accepted (no backpressure).
module adler32_checker
  import adler32_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic        last_data,
  input  logic [7:0]  data,
  output logic        result_valid,
  output logic        checksum_ok,
  output logic [31:0] computed_checksum,
  output logic [31:0] received_checksum,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] a_new;
  logic [15:0] b_new;
  logic [1:0]  cnt;
  logic [23:0] shift;
  logic        trailer_done;
  logic [31:0] trailer_word;

  adler32_mod_add u_add_a (
    .x   (a_q),
    .y   ({8'h00, data}),
    .sum (a_new)
  );

  // B folds in this cycle's updated A, so the two adders are chained.
  adler32_mod_add u_add_b (
    .x   (b_q),
    .y   (a_new),
    .sum (b_new)
  );

  assign trailer_done = data_valid && (state == ST_TRAILER) &&
                        (cnt == 2'(TRAILER_BYTES - 1));
  assign trailer_word = {shift, data};
  assign busy         = (state == ST_TRAILER);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PAYLOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PAYLOAD: if (data_valid && last_data) state_nxt = ST_TRAILER;
      ST_TRAILER: if (trailer_done)            state_nxt = ST_PAYLOAD;
      default:                                 state_nxt = ST_PAYLOAD;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      a_q               <= ADLER_A_INIT;
      b_q               <= ADLER_B_INIT;
      cnt               <= 2'd0;
      shift             <= 24'd0;
      result_valid      <= 1'b0;
      checksum_ok       <= 1'b0;
      computed_checksum <= {ADLER_B_INIT, ADLER_A_INIT};
      received_checksum <= 32'd0;
    end else begin
      result_valid <= 1'b0;
      if (data_valid) begin
        if (state == ST_PAYLOAD) begin
          a_q <= a_new;
          b_q <= b_new;
          cnt <= 2'd0;
        end else if (trailer_done) begin
          computed_checksum <= {b_q, a_q};
          received_checksum <= trailer_word;
          checksum_ok       <= ({b_q, a_q} == trailer_word);
          result_valid      <= 1'b1;
          a_q               <= ADLER_A_INIT;
          b_q               <= ADLER_B_INIT;
          cnt               <= 2'd0;
          shift             <= 24'd0;
        end else begin
          shift <= trailer_word[23:0];
          cnt   <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adler32_checker.sv
// Directed self-checking bench for adler32_checker: known vectors, wrap, gaps, back-to-back, mid-frame reset.
module tb_adler32_checker;

  logic        clock;
  logic        rst_n;
  logic        data_valid;
  logic        last_data;
  logic [7:0]  data;
  logic        result_valid;
  logic        checksum_ok;
  logic [31:0] computed_checksum;
  logic [31:0] received_checksum;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int exp_pulses = 0;

  logic [7:0]  pl[$];
  logic [31:0] cap_comp[$];
  logic [31:0] cap_recv[$];
  logic        cap_ok[$];
  logic [31:0] ref_sum;

  adler32_checker dut (
    .clock             (clock),
    .rst_n             (rst_n),
    .data_valid        (data_valid),
    .last_data         (last_data),
    .data              (data),
    .result_valid      (result_valid),
    .checksum_ok       (checksum_ok),
    .computed_checksum (computed_checksum),
    .received_checksum (received_checksum),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      cap_comp.push_back(computed_checksum);
      cap_recv.push_back(received_checksum);
      cap_ok.push_back(checksum_ok);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] adler_ref();
    int a = 1;
    int b = 0;
    foreach (pl[i]) begin
      a = (a + int'(pl[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last, input int gaps, input logic noisy);
    int n;
    n = (gaps > 0) ? int'($urandom_range(0, gaps)) : 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      data_valid = 1'b0;
      last_data  = noisy;
      data       = 8'($urandom);
      @(posedge clock);
    end
    @(negedge clock);
    data_valid = 1'b1;
    data       = d;
    last_data  = last;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    last_data  = 1'b0;
  endtask

  // Ends 1 time unit after the edge accepting the 4th trailer byte.
  task automatic send_frame(input logic [31:0] trailer, input int gaps, input logic noisy);
    for (int i = 0; i < pl.size(); i++)
      send_byte(pl[i], (i == pl.size() - 1), gaps, noisy);
    chk("busy_in_trailer", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++)
      send_byte(trailer[31 - 8*k -: 8], noisy, gaps, noisy);
    exp_pulses++;
    chk("result_latency", {31'd0, result_valid}, 32'd1);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic end_frame(input logic [31:0] comp, input logic [31:0] recv, input logic ok);
    @(posedge clock);
    #1;
    chk("result_one_cycle", {31'd0, result_valid}, 32'd0);
    chk("computed", computed_checksum, comp);
    chk("received", received_checksum, recv);
    chk("checksum_ok", {31'd0, checksum_ok}, {31'd0, ok});
    chk("pulse_count", cap_comp.size(), exp_pulses);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    last_data  = 1'b0;
    data       = 8'h00;
    #12;
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_checksum_ok", {31'd0, checksum_ok}, 32'd0);
    chk("rst_computed", computed_checksum, 32'h0000_0001);
    chk("rst_received", received_checksum, 32'h0000_0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #11 rst_n = 1'b1;

    // "Wikipedia", no gaps
    pl = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    send_frame(32'h11E6_0398, 0, 1'b0);
    end_frame(32'h11E6_0398, 32'h11E6_0398, 1'b1);

    // Single 0xFF, correct then corrupted trailer
    pl = '{8'hFF};
    send_frame(32'h0100_0100, 0, 1'b0);
    end_frame(32'h0100_0100, 32'h0100_0100, 1'b1);
    send_frame(32'h0100_0101, 0, 1'b0);
    end_frame(32'h0100_0100, 32'h0100_0101, 1'b0);

    // 257 x 0xFF forces A to wrap past the modulus
    pl.delete();
    for (int i = 0; i < 257; i++) pl.push_back(8'hFF);
    ref_sum = adler_ref();
    send_frame(ref_sum, 0, 1'b0);
    chk("wrap_a_field", {16'd0, computed_checksum[15:0]}, 32'h0000_000F);
    end_frame(ref_sum, ref_sum, 1'b1);

    // "Wikipedia" with random stalls and last_data noise
    pl = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    send_frame(32'h11E6_0398, 3, 1'b1);
    end_frame(32'h11E6_0398, 32'h11E6_0398, 1'b1);

    // Back-to-back: frame 2 starts in frame 1's result_valid cycle
    pl = '{8'hFF};
    send_frame(32'h0100_0100, 0, 1'b0);
    pl = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    send_frame(32'h11E6_0398, 0, 1'b0);
    end_frame(32'h11E6_0398, 32'h11E6_0398, 1'b1);
    chk("b2b_first_comp", cap_comp[cap_comp.size() - 2], 32'h0100_0100);
    chk("b2b_first_ok", {31'd0, cap_ok[cap_ok.size() - 2]}, 32'd1);

    // Reset after 2nd trailer byte discards the frame
    send_byte(8'h12, 1'b0, 0, 1'b0);
    send_byte(8'h34, 1'b1, 0, 1'b0);
    send_byte(8'hAA, 1'b0, 0, 1'b0);
    send_byte(8'hBB, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_computed", computed_checksum, 32'h0000_0001);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("midrst_no_pulse", cap_comp.size(), exp_pulses);

    pl = '{8'h00};
    send_frame(32'h0001_0001, 0, 1'b0);
    end_frame(32'h0001_0001, 32'h0001_0001, 1'b1);

    repeat (3) @(posedge clock);
    #1;
    chk("final_pulse_count", cap_comp.size(), exp_pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
